// File: rtl/adder_rr_sched_if.sv
// adder_rr_sched_if: requester and result handshake bundle for the shared adder scheduler
interface adder_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int W = 8,
    parameter int IDW = 2
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic [N_REQ*W-1:0] a_flat;
    logic [N_REQ*W-1:0] b_flat;
    logic [W-1:0] res_sum;
    logic res_carry;
    logic [IDW-1:0] res_id;
    logic res_valid;
    logic res_ready;
    modport master (
        output req, a_flat, b_flat, res_ready,
        input ack, res_sum, res_carry, res_id, res_valid
    );
    modport slave (
        input req, a_flat, b_flat, res_ready,
        output ack, res_sum, res_carry, res_id, res_valid
    );
endinterface

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: round-robin arbitration of N_REQ requesters onto one registered W-bit adder
module adder_rr_sched #(
    parameter int N_REQ = 4,
    parameter int W = 8,
    parameter int IDW = 2
) (
    input logic clk,
    input logic rst_n,
    input logic ena,
    adder_rr_sched_if.slave bus,
    output logic busy,
    output logic [7:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;
    state_t state, state_nxt;
    logic [IDW-1:0] ptr, win, id_q;
    logic [W-1:0] a_q, b_q;
    logic found, grant;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = grant ? EXEC : IDLE;
        else if (state == EXEC) state_nxt = OUT;
        else if (state == OUT) state_nxt = (bus.res_valid && bus.res_ready) ? IDLE : OUT;
    end
    // first requester at or after ptr, wrapping around
    always_comb begin
        logic [IDW-1:0] idx;
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    always_comb begin
        grant = (state == IDLE) && ena && found;
        busy = state != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            id_q <= '0;
            a_q <= '0;
            b_q <= '0;
            bus.ack <= '0;
            bus.res_sum <= '0;
            bus.res_carry <= 1'b0;
            bus.res_id <= '0;
            bus.res_valid <= 1'b0;
            op_count <= '0;
        end else begin
            bus.ack <= grant ? (N_REQ'(1) << win) : '0;
            if (grant) begin
                a_q <= bus.a_flat[int'(win)*W +: W];
                b_q <= bus.b_flat[int'(win)*W +: W];
                id_q <= win;
                ptr <= IDW'((int'(win) + 1) % N_REQ);
            end
            if (state == EXEC) begin
                {bus.res_carry, bus.res_sum} <= {1'b0, a_q} + {1'b0, b_q};
                bus.res_id <= id_q;
                bus.res_valid <= 1'b1;
            end
            if (state == OUT && bus.res_valid && bus.res_ready) begin
                bus.res_valid <= 1'b0;
                op_count <= op_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: directed checks of grant order, handshake, enable, reset and counter wrap
module tb_adder_rr_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena;
    logic busy;
    logic [7:0] op_count;
    int n_checks = 0;
    int n_fail = 0;
    adder_rr_sched_if #(.N_REQ(4), .W(8), .IDW(2)) bus();
    adder_rr_sched #(.N_REQ(4), .W(8), .IDW(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .bus(bus),
        .busy(busy),
        .op_count(op_count)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.a_flat[i*8 +: 8] = a;
        bus.b_flat[i*8 +: 8] = b;
    endtask
    task automatic do_op(input string tag, input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] es, input logic ec);
        int n;
        n = 0;
        set_ops(i, a, b);
        bus.req[i] = 1'b1;
        tick();
        while (bus.ack == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ack"}, 32'(bus.ack), 32'(1) << i);
        bus.req[i] = 1'b0;
        tick();
        check({tag, "_valid"}, 32'(bus.res_valid), 1);
        check({tag, "_sum"}, 32'(bus.res_sum), 32'(es));
        check({tag, "_carry"}, 32'(bus.res_carry), 32'(ec));
        check({tag, "_id"}, 32'(bus.res_id), i);
        tick();
        check({tag, "_vdrop"}, 32'(bus.res_valid), 0);
    endtask
    initial begin
        logic [3:0] acc;
        ena = 1'b1;
        bus.req = '0;
        bus.a_flat = '0;
        bus.b_flat = '0;
        bus.res_ready = 1'b1;
        tick();
        tick();
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_valid", 32'(bus.res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cnt", 32'(op_count), 0);
        check("rst_sum", 32'(bus.res_sum), 0);
        rst_n = 1'b1;
        tick();
        do_op("basic", 0, 8'h12, 8'h34, 8'h46, 1'b0);
        check("basic_cnt", 32'(op_count), 1);
        check("basic_idle", 32'(busy), 0);
        do_op("ff01", 0, 8'hFF, 8'h01, 8'h00, 1'b1);
        do_op("8080", 0, 8'h80, 8'h80, 8'h00, 1'b1);
        check("cnt3", 32'(op_count), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 8'(8'h10 * (i + 1)), 8'(i));
        tick();
        bus.req = 4'b1111;
        for (int c = 1; c <= 13; c++) begin
            tick();
            check($sformatf("rr_ack%0d", c), 32'(bus.ack),
                  (c % 3 == 1) ? (32'(1) << (((c - 1) / 3) % 4)) : 0);
            if (c % 3 == 2) begin
                check($sformatf("rr_id%0d", c), 32'(bus.res_id), ((c - 2) / 3) % 4);
                check($sformatf("rr_sum%0d", c), 32'(bus.res_sum),
                      8'h10 * (((c - 2) / 3) % 4 + 1) + ((c - 2) / 3) % 4);
            end
        end
        bus.req = '0;
        tick();
        tick();
        check("rr_idle", 32'(busy), 0);
        bus.res_ready = 1'b0;
        set_ops(1, 8'h40, 8'h02);
        bus.req = 4'b0010;
        tick();
        check("bp_ack1", 32'(bus.ack), 4'b0010);
        bus.req = '0;
        tick();
        check("bp_valid", 32'(bus.res_valid), 1);
        check("bp_sum", 32'(bus.res_sum), 8'h42);
        set_ops(2, 8'h05, 8'h06);
        bus.req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", 32'(bus.res_valid), 1);
            check("bp_hold_sum", 32'(bus.res_sum), 8'h42);
            check("bp_hold_id", 32'(bus.res_id), 1);
            check("bp_hold_busy", 32'(busy), 1);
            check("bp_hold_ack", 32'(bus.ack), 0);
        end
        bus.res_ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(bus.res_valid), 0);
        check("bp_done_ack", 32'(bus.ack), 0);
        tick();
        check("bp_ack2", 32'(bus.ack), 4'b0100);
        bus.req = '0;
        tick();
        check("bp_sum2", 32'(bus.res_sum), 8'h0B);
        tick();
        ena = 1'b0;
        set_ops(2, 8'h20, 8'h05);
        bus.req = 4'b0100;
        acc = '0;
        repeat (10) begin
            tick();
            acc |= bus.ack;
        end
        check("ena_noack", 32'(acc), 0);
        check("ena_idle", 32'(busy), 0);
        ena = 1'b1;
        tick();
        check("ena_ack", 32'(bus.ack), 4'b0100);
        bus.req = '0;
        ena = 1'b0;
        tick();
        check("ena_valid", 32'(bus.res_valid), 1);
        check("ena_sum", 32'(bus.res_sum), 8'h25);
        check("ena_id", 32'(bus.res_id), 2);
        tick();
        check("ena_vdrop", 32'(bus.res_valid), 0);
        ena = 1'b1;
        set_ops(0, 8'h11, 8'h22);
        bus.req = 4'b0001;
        tick();
        check("rx_ack", 32'(bus.ack), 4'b0001);
        bus.req = '0;
        rst_n = 1'b0;
        #1;
        check("rx_ack0", 32'(bus.ack), 0);
        check("rx_busy", 32'(busy), 0);
        check("rx_sum", 32'(bus.res_sum), 0);
        check("rx_cnt", 32'(op_count), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rx_lost", 32'(bus.res_valid), 0);
        bus.res_ready = 1'b0;
        set_ops(0, 8'h30, 8'h03);
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        tick();
        check("ro_valid", 32'(bus.res_valid), 1);
        check("ro_sum", 32'(bus.res_sum), 8'h33);
        rst_n = 1'b0;
        #1;
        check("ro_valid0", 32'(bus.res_valid), 0);
        check("ro_sum0", 32'(bus.res_sum), 0);
        check("ro_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        set_ops(0, 8'h01, 8'h01);
        bus.req = 4'b0001;
        repeat (765) tick();
        check("wrap_255", 32'(op_count), 255);
        repeat (3) tick();
        check("wrap_0", 32'(op_count), 0);
        bus.req = '0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
